result_dump_unit: RTL and testbench

- Hardware sink for the processor result port.
- Captures each 40-bit `data` word presented while `enable` is high into a small FIFO.
- Serializes every captured word as bytes, MSB first, over a valid/ready byte stream toward a host link.
- Replaces the simulation-only file dump with a synthesizable path so results leave the chip on real hardware.

---
 rtl/result_dump_unit_if.sv | 10 +
 rtl/result_dump_unit.sv | 147 ++++++++++++++
 tb/tb_result_dump_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/result_dump_unit_if.sv
// Byte-stream link from the result dump unit toward the host.
// master drives the byte and its valid flag; slave returns ready.
interface result_dump_unit_if;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_ready;

    modport master (output out_valid, output out_byte, input out_ready);
    modport slave  (input out_valid, input out_byte, output out_ready);
endinterface

// File: rtl/result_dump_unit.sv
// Result sink: buffers processor result words in a FIFO and streams them out as bytes, MSB first.
// Optional DUMP_DELIM_EN appends a 8'h0A delimiter byte after every word.
module result_dump_unit #(
    parameter int unsigned DATA_W = 40,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NBYTES = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        data,
    result_dump_unit_if.master       dump,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   word_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PAD_W = NBYTES * 8;
    localparam int unsigned IDX_W = $clog2(NBYTES + 1);

`ifdef DUMP_DELIM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
`endif

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [PAD_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic full_c;
    logic push;
    logic pop;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;

        // Fullness is judged before any same-edge pop, so a full FIFO drops.
        full_c     = (count_q == CNT_FULL);
        push       = enable && !full_c;
        overflow_d = overflow_q || (enable && full_c);

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    byte_idx_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (dump.out_ready) begin
                    if (byte_idx_q != LAST_IDX) begin
                        byte_idx_d = byte_idx_q + IDX_ONE;
                        shift_d    = shift_q << 8;
                    end else if (count_q != '0) begin
                        pop        = 1'b1;
                        byte_idx_d = '0;
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Padding bits above DATA_W stay zero in the byte image.
        if (pop) begin
            shift_d             = '0;
            shift_d[DATA_W-1:0] = mem_q[rd_ptr_q];
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            byte_idx_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_comb begin
        dump.out_valid = (state_q == SEND);
        dump.out_byte  = 8'h00;
        if (state_q == SEND) begin
`ifdef DUMP_DELIM_EN
            dump.out_byte = (byte_idx_q == LAST_IDX) ? 8'h0A : shift_q[PAD_W-1 -: 8];
`else
            dump.out_byte = shift_q[PAD_W-1 -: 8];
`endif
        end
    end

    assign full       = full_c;
    assign empty      = (count_q == '0) && (state_q == IDLE);
    assign overflow   = overflow_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_result_dump_unit.sv
// Scoreboard bench for result_dump_unit: expected bytes are queued as words are driven
// and checked in order as the byte stream hands them over.
module tb_result_dump_unit;

`ifdef DUMP_DELIM_EN
    localparam int BPW = 6;
`else
    localparam int BPW = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [39:0] data;
    logic        full, empty, overflow;
    logic [4:0]  word_count;

    result_dump_unit_if dump_if();

    result_dump_unit #(.DATA_W(40), .DEPTH(16), .NBYTES(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data       (data),
        .dump       (dump_if),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_cnt = 0;
    int mark_cnt = 0;
    int first_hs_cyc = 0;
    int last_hs_cyc  = 0;
    logic [7:0] exp_q[$];
    bit         stall_prev = 0;
    logic [7:0] stall_byte = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Stream monitor: compares every accepted byte and checks stalled bytes are held.
    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_valid", dump_if.out_valid, 1);
                check_eq("hold_byte", dump_if.out_byte, stall_byte);
            end
            stall_prev = dump_if.out_valid && !dump_if.out_ready;
            stall_byte = dump_if.out_byte;
            if (dump_if.out_valid && dump_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_byte", dump_if.out_valid, 0);
                end else begin
                    check_eq("stream_byte", dump_if.out_byte, exp_q.pop_front());
                end
                if (hs_cnt == mark_cnt) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [39:0] w, input bit accept);
        logic [39:0] tmp;
        enable = 1'b1;
        data   = w;
        if (accept) begin
            tmp = w;
            for (int b = 0; b < 5; b++) begin
                exp_q.push_back(tmp[39:32]);
                tmp = tmp << 8;
            end
`ifdef DUMP_DELIM_EN
            exp_q.push_back(8'h0A);
`endif
        end
        step();
    endtask

    task automatic do_reset();
        rst               = 1'b0;
        enable            = 1'b0;
        data              = '0;
        dump_if.out_ready = 1'b0;
        exp_q.delete();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic drain(input string tag, input bit toggle, input int limit);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0 && !dump_if.out_valid) break;
            dump_if.out_ready = toggle ? pat[i % 4] : 1'b1;
            step();
        end
        check_eq({tag, "_left"}, exp_q.size(), 0);
        check_eq({tag, "_empty"}, empty, 1);
        check_eq({tag, "_valid"}, dump_if.out_valid, 0);
    endtask

    initial begin
        do_reset();
        rst = 1'b0;
        #1;
        check_eq("rst_valid", dump_if.out_valid, 0);
        check_eq("rst_byte", dump_if.out_byte, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_count", word_count, 0);
        do_reset();

        // Single word with ready high, including first-byte latency.
        dump_if.out_ready = 1'b1;
        drive_word(40'h12_3456_789A, 1);
        enable = 1'b0;
        check_eq("lat_empty", empty, 0);
        check_eq("lat_count", word_count, 1);
        check_eq("lat_valid0", dump_if.out_valid, 0);
        step();
        check_eq("lat_valid1", dump_if.out_valid, 1);
        check_eq("lat_byte", dump_if.out_byte, 8'h12);
        check_eq("lat_popped", word_count, 0);
        drain("single", 0, 40);

        // Backpressure with ready pattern 1,0,0,1.
        dump_if.out_ready = 1'b0;
        drive_word(40'h12_3456_789A, 1);
        enable = 1'b0;
        drain("bp", 1, 80);

        // Three-word burst must stream without a valid gap.
        dump_if.out_ready = 1'b1;
        mark_cnt = hs_cnt;
        drive_word(40'h1, 1);
        drive_word(40'h2, 1);
        drive_word(40'h3, 1);
        enable = 1'b0;
        drain("burst", 0, 60);
        check_eq("burst_count", hs_cnt - mark_cnt, 3 * BPW);
        check_eq("burst_span", last_hs_cyc - first_hs_cyc, 3 * BPW - 1);

        // Fill and overflow: word 0 is already in the serializer, so 0..16 fit and 17 drops.
        do_reset();
        for (int i = 0; i < 18; i++) drive_word(40'(i), i <= 16);
        enable = 1'b0;
        check_eq("fill_count", word_count, 16);
        check_eq("fill_full", full, 1);
        check_eq("fill_overflow", overflow, 1);
        drain("fill", 0, 400);
        check_eq("fill_ovf_sticky", overflow, 1);

        // Push at full coinciding with the last-byte pop is still dropped.
        do_reset();
        for (int i = 0; i < 17; i++) drive_word(40'(100 + i), 1);
        enable = 1'b0;
        check_eq("pf_full", full, 1);
        check_eq("pf_ovf0", overflow, 0);
        dump_if.out_ready = 1'b1;
        for (int i = 0; i < BPW - 1; i++) step();
        check_eq("pf_count_pre", word_count, 16);
        drive_word(40'hDE_AD00_BEEF, 0);
        enable = 1'b0;
        check_eq("pf_count", word_count, 15);
        check_eq("pf_overflow", overflow, 1);
        check_eq("pf_full_after", full, 0);
        drain("pf", 0, 400);

        // Reset after two bytes of a word have been accepted.
        do_reset();
        dump_if.out_ready = 1'b1;
        mark_cnt = hs_cnt;
        drive_word(40'hA1_B2C3_D4E5, 1);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (hs_cnt - mark_cnt >= 2) break;
            step();
        end
        check_eq("mid_two_bytes", hs_cnt - mark_cnt, 2);
        rst = 1'b0;
        #1;
        check_eq("mid_valid", dump_if.out_valid, 0);
        check_eq("mid_byte", dump_if.out_byte, 0);
        check_eq("mid_empty", empty, 1);
        check_eq("mid_count", word_count, 0);
        exp_q.delete();
        step();
        rst = 1'b1;
        mark_cnt = hs_cnt;
        for (int i = 0; i < 10; i++) step();
        check_eq("mid_no_resume", hs_cnt - mark_cnt, 0);
        check_eq("mid_idle_valid", dump_if.out_valid, 0);
        drive_word(40'h55_6677_8899, 1);
        enable = 1'b0;
        drain("mid_new", 0, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
